// File: rtl/cpca_pkg.sv
// Shared types and defaults for the divide-array checker.
package cpca_pkg;

  localparam int unsigned QW_DEF = 5;
  localparam int unsigned DW_DEF = 7;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StAddRem,
    StDone
  } state_e;

endpackage

// File: rtl/cpca_div_checker_if.sv
// Operand/result handshake bundle for cpca_div_checker.
interface cpca_div_checker_if #(
  parameter int unsigned QW = 5,
  parameter int unsigned DW = 7
);
  localparam int unsigned PW = QW + DW;

  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [PW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic [QW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          match;
  logic          rem_ovf;
  logic          div_zero;
  logic          busy;

  modport master (
    output in_valid, mode, dividend, divisor, quotient, remainder, out_ready,
    input  in_ready, out_valid, product, match, rem_ovf, div_zero, busy
  );

  modport slave (
    input  in_valid, mode, dividend, divisor, quotient, remainder, out_ready,
    output in_ready, out_valid, product, match, rem_ovf, div_zero, busy
  );

endinterface

// File: rtl/cpca_shift_add_step.sv
// One MSB-first shift-add multiply step: acc_next = (acc << 1) + (qbit ? divisor : 0).
module cpca_shift_add_step #(
  parameter int unsigned DW = 7,
  parameter int unsigned AW = 13
) (
  input  logic [AW-1:0] acc,
  input  logic          qbit,
  input  logic [DW-1:0] divisor,
  output logic [AW-1:0] acc_next
);

  always_comb begin
    acc_next = (acc << 1) + (qbit ? AW'(divisor) : '0);
  end

endmodule

// File: rtl/cpca_div_checker.sv
// Rebuilds quotient*divisor(+remainder) by shift-add and checks it against the dividend.
module cpca_div_checker
  import cpca_pkg::*;
#(
  parameter int unsigned QW = QW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input logic               clk,
  input logic               rst,
  cpca_div_checker_if.slave bus
);

  localparam int unsigned PW = QW + DW;
  localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;

  state_e        state_q;
  logic          mode_q;
  logic [PW-1:0] dividend_q;
  logic [DW-1:0] divisor_q;
  logic [QW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;
  logic [PW:0]   acc_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] product_q;
  logic          match_q;
  logic          rem_ovf_q;
  logic          div_zero_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [PW:0]   acc_step;
  logic [PW:0]   sum;
  logic          rem_ovf_c;
  logic          div_zero_c;

  cpca_shift_add_step #(
    .DW(DW),
    .AW(PW + 1)
  ) u_step (
    .acc      (acc_q),
    .qbit     (quotient_q[count_q]),
    .divisor  (divisor_q),
    .acc_next (acc_step)
  );

  // Extra acc bit catches the carry out of the remainder add.
  always_comb begin
    sum        = acc_q + (PW + 1)'(remainder_q);
    rem_ovf_c  = remainder_q >= divisor_q;
    div_zero_c = divisor_q == '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= MODE_MUL;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      product_q   <= '0;
      match_q     <= 1'b0;
      rem_ovf_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            mode_q      <= bus.mode;
            dividend_q  <= bus.dividend;
            divisor_q   <= bus.divisor;
            quotient_q  <= bus.quotient;
            remainder_q <= bus.remainder;
            acc_q       <= '0;
            count_q     <= CW'(QW - 1);
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_step;
          count_q <= count_q - 1'b1;
          if (count_q == '0) state_q <= StAddRem;
        end
        StAddRem: begin
          if (mode_q == MODE_DIV) begin
            acc_q      <= sum;
            product_q  <= sum[PW-1:0];
            rem_ovf_q  <= rem_ovf_c;
            div_zero_q <= div_zero_c;
            match_q    <= (sum[PW-1:0] == dividend_q) && !rem_ovf_c && !div_zero_c && !sum[PW];
          end else begin
            product_q  <= acc_q[PW-1:0];
            rem_ovf_q  <= 1'b0;
            div_zero_q <= 1'b0;
            match_q    <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            match_q     <= 1'b0;
            rem_ovf_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.match     = match_q;
  assign bus.rem_ovf   = rem_ovf_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cpca_div_checker.sv
// Directed plus randomized checks of cpca_div_checker against an arithmetic reference.
module tb_cpca_div_checker;

  localparam int unsigned QW = 5;
  localparam int unsigned DW = 7;
  localparam int unsigned PW = QW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cpca_div_checker_if #(.QW(QW), .DW(DW)) bus ();

  cpca_div_checker #(.QW(QW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.mode      = 1'($urandom);
    bus.dividend  = PW'($urandom);
    bus.divisor   = DW'($urandom);
    bus.quotient  = QW'($urandom);
    bus.remainder = DW'($urandom);
  endtask

  // One full transaction; expected values come from plain arithmetic on the operands.
  task automatic do_op(input bit md, input int dd, input int dv, input int q, input int r,
                       input int hold);
    int  full, e_prod, lat;
    bit  e_sovf, e_rov, e_dz, e_match, seen;
    full    = q * dv + (md ? r : 0);
    e_prod  = full % (1 << PW);
    e_sovf  = md && (full >= (1 << PW));
    e_rov   = md && (r >= dv);
    e_dz    = md && (dv == 0);
    e_match = md && (e_prod == dd) && !e_rov && !e_dz && !e_sovf;

    @(negedge clk);
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.mode      = md;
    bus.dividend  = PW'(dd);
    bus.divisor   = DW'(dv);
    bus.quotient  = QW'(q);
    bus.remainder = DW'(r);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();

    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (lat == 1) begin
        check("busy_run", int'(bus.busy), 1);
        check("in_ready_run", int'(bus.in_ready), 0);
      end
      lat++;
    end
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, QW + 2);
    check("product", int'(bus.product), e_prod);
    check("match", int'(bus.match), int'(e_match));
    check("rem_ovf", int'(bus.rem_ovf), int'(e_rov));
    check("div_zero", int'(bus.div_zero), int'(e_dz));

    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      scramble_inputs();
      @(negedge clk);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_product", int'(bus.product), e_prod);
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("exit_valid", int'(bus.out_valid), 0);
    check("exit_in_ready", int'(bus.in_ready), 1);
    check("exit_busy", int'(bus.busy), 0);
    check("exit_flags", int'({bus.match, bus.rem_ovf, bus.div_zero}), 0);
  endtask

  initial begin
    int  dv, q, r, dd;
    bit  md, ov_seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_product", int'(bus.product), 0);
    check("rst_flags", int'({bus.match, bus.rem_ovf, bus.div_zero}), 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b1, 100, 7, 14, 2, 0);
    do_op(1'b1, 100, 7, 13, 2, 0);
    do_op(1'b1, 100, 7, 13, 9, 0);
    do_op(1'b1, 0, 0, 5, 3, 0);
    do_op(1'b0, 0, 127, 31, 0, 0);
    do_op(1'b1, 4064, 127, 31, 126, 4);

    // Abort mid-run: reset must return to idle and suppress the result.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode     = 1'b1;
    bus.dividend = PW'(100);
    bus.divisor  = DW'(7);
    bus.quotient = QW'(14);
    bus.remainder = DW'(2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("abort_no_valid", int'(ov_seen), 0);
    do_op(1'b1, 100, 7, 14, 2, 0);

    for (int n = 0; n < 24; n++) begin
      md = 1'($urandom);
      dv = int'($urandom_range(0, 127));
      q  = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        r  = (dv > 0) ? int'($urandom_range(0, dv - 1)) : 0;
        dd = q * dv + r;
      end else begin
        r  = int'($urandom_range(0, 127));
        dd = int'($urandom_range(0, 4095));
      end
      do_op(md, dd, dv, q, r, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
